pc_gen_ras: RTL and testbench

- Next-generation next-PC unit: owns the PC register and computes next PC each cycle.
- Adds stall hold, exception entry/return (EPC), and a parametrised return-address stack (RAS) that checks every `jr $ra` against the value actually read from rs.
- Sits between the control unit (npc_op, link, rs_is_ra) and instruction memory (pc) in the single-cycle CPU. Same slot as the existing NPC/PC pair, which it replaces.

---
 rtl/pc_gen_ras_pkg.sv | 23 ++
 rtl/pc_gen_ras_if.sv | 29 ++
 rtl/pc_ras.sv | 98 +++++++++
 rtl/pc_gen_ras.sv | 113 +++++++++++
 tb/tb_pc_gen_ras.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_gen_ras_pkg.sv
// Shared definitions for the next-PC unit: 3-bit next-PC select codes and
// small address helpers used by the PC mux and the alignment check.
package pc_gen_ras_pkg;

  typedef enum logic [2:0] {
    NPC_PLUS4  = 3'b000,
    NPC_BRANCH = 3'b001,
    NPC_JUMP   = 3'b010,
    NPC_JR     = 3'b011,
    NPC_EXC    = 3'b100,
    NPC_ERET   = 3'b101
  } npc_op_e;

  // Word-aligned, sign-extended branch displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

  function automatic logic word_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_gen_ras_if.sv
// Control/fetch-side bundle of the next-PC unit. The master modport is the
// control unit side; the slave modport is the next-PC unit itself.
interface pc_gen_ras_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic [2:0]       npc_op;
  logic [25:0]      imm;
  logic [31:0]      rd1;
  logic             link;
  logic             rs_is_ra;
  logic [31:0]      pc;
  logic [31:0]      npc;
  logic [31:0]      epc;
  logic [31:0]      ras_top;
  logic             ras_valid;
  logic [CNT_W-1:0] ras_miss_cnt;
  logic             misalign;

  modport master (
    output stall, npc_op, imm, rd1, link, rs_is_ra,
    input  pc, npc, epc, ras_top, ras_valid, ras_miss_cnt, misalign
  );

  modport slave (
    input  stall, npc_op, imm, rd1, link, rs_is_ra,
    output pc, npc, epc, ras_top, ras_valid, ras_miss_cnt, misalign
  );
endinterface

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with saturating occupancy; every pop
// is compared against the real jump target and mismatches are counted.
module pc_ras #(
  parameter int RAS_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             push,
  input  logic [31:0]      push_data,
  input  logic             pop,
  input  logic [31:0]      pop_cmp,
  output logic [31:0]      top,
  output logic             valid,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(RAS_DEPTH);
  localparam logic [PTR_W:0]   OCC_ZERO = (PTR_W+1)'(0);
  localparam logic [CNT_W-1:0] MISS_MAX = {CNT_W{1'b1}};

  logic [31:0]      buf_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   occ_q, occ_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic [PTR_W-1:0] top_idx_s;
  logic [PTR_W-1:0] wr_idx_s;
  logic             wr_en_s;
  logic             empty_s;
  logic             miss_s;

  // ptr_q is the next free slot, so the top lives one below it.
  assign top_idx_s = ptr_q - PTR_W'(1);
  assign empty_s   = (occ_q == OCC_ZERO);
  assign miss_s    = pop && (empty_s || (buf_q[top_idx_s] != pop_cmp));

  // Next-state of pointer, occupancy and write port; pop is resolved before push.
  always_comb begin
    ptr_d    = ptr_q;
    occ_d    = occ_q;
    wr_en_s  = 1'b0;
    wr_idx_s = ptr_q;
    if (pop && push && !empty_s) begin
      wr_en_s  = 1'b1;
      wr_idx_s = top_idx_s;
    end else if (push) begin
      wr_en_s  = 1'b1;
      wr_idx_s = ptr_q;
      ptr_d    = ptr_q + PTR_W'(1);
      if (occ_q != OCC_FULL) begin
        occ_d = occ_q + (PTR_W+1)'(1);
      end else begin
        occ_d = occ_q;
      end
    end else if (pop && !empty_s) begin
      ptr_d = top_idx_s;
      occ_d = occ_q - (PTR_W+1)'(1);
    end else begin
      ptr_d = ptr_q;
      occ_d = occ_q;
    end
  end

  // Saturating mismatch counter.
  always_comb begin
    miss_d = miss_q;
    if (miss_s && (miss_q != MISS_MAX)) begin
      miss_d = miss_q + CNT_W'(1);
    end else begin
      miss_d = miss_q;
    end
  end

  // Stack state; everything holds while en is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q  <= {PTR_W{1'b0}};
      occ_q  <= OCC_ZERO;
      miss_q <= {CNT_W{1'b0}};
      for (int i = 0; i < RAS_DEPTH; i++) begin
        buf_q[i] <= 32'h0000_0000;
      end
    end else if (en) begin
      ptr_q  <= ptr_d;
      occ_q  <= occ_d;
      miss_q <= miss_d;
      if (wr_en_s) begin
        buf_q[wr_idx_s] <= push_data;
      end
    end
  end

  assign top      = empty_s ? 32'h0000_0000 : buf_q[top_idx_s];
  assign valid    = !empty_s;
  assign miss_cnt = miss_q;

endmodule

// File: rtl/pc_gen_ras.sv
// Next-PC unit: PC/EPC registers, next-PC mux and RAS-based return checking.
// Optional macro PC_ALIGN_CHK_EN turns misaligned JR/ERET targets into exceptions.
module pc_gen_ras
  import pc_gen_ras_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter int          RAS_DEPTH = 4,
  parameter int          CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rstn,
  pc_gen_ras_if.slave   bus
);
  npc_op_e     op_s;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] pc4_s;
  logic [31:0] npc_raw_s;
  logic [31:0] npc_s;
  logic        misalign_s;
  logic        exc_take_s;
  logic        push_s;
  logic        pop_s;

  assign op_s  = npc_op_e'(bus.npc_op);
  assign pc4_s = pc_q + 32'h0000_0004;

  // Architectural next-PC selection before the alignment check.
  always_comb begin
    npc_raw_s = pc4_s;
    case (op_s)
      NPC_PLUS4:  npc_raw_s = pc4_s;
      NPC_BRANCH: npc_raw_s = pc4_s + branch_offset(bus.imm[15:0]);
      NPC_JUMP:   npc_raw_s = {pc4_s[31:28], bus.imm, 2'b00};
      NPC_JR:     npc_raw_s = bus.rd1;
      NPC_EXC:    npc_raw_s = EXC_VEC;
      NPC_ERET:   npc_raw_s = epc_q;
      default:    npc_raw_s = pc4_s;
    endcase
  end

`ifdef PC_ALIGN_CHK_EN
  // Register-sourced targets are the only ones that can be misaligned.
  always_comb begin
    misalign_s = 1'b0;
    if (((op_s == NPC_JR) && word_misaligned(bus.rd1)) ||
        ((op_s == NPC_ERET) && word_misaligned(epc_q))) begin
      misalign_s = 1'b1;
    end else begin
      misalign_s = 1'b0;
    end
  end
  assign npc_s = misalign_s ? EXC_VEC : npc_raw_s;
`else
  assign misalign_s = 1'b0;
  assign npc_s      = npc_raw_s;
`endif

  assign exc_take_s = (op_s == NPC_EXC) || misalign_s;
  assign push_s     = bus.link && (op_s != NPC_EXC);
  assign pop_s      = (op_s == NPC_JR) && bus.rs_is_ra;

  // PC/EPC next state; stall freezes both.
  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    if (!bus.stall) begin
      pc_d = npc_s;
      if (exc_take_s) begin
        epc_d = pc_q;
      end else begin
        epc_d = epc_q;
      end
    end else begin
      pc_d  = pc_q;
      epc_d = epc_q;
    end
  end

  // PC and EPC registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q  <= RESET_PC;
      epc_q <= 32'h0000_0000;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
    end
  end

  pc_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .CNT_W     (CNT_W)
  ) u_ras (
    .clk       (clk),
    .rstn      (rstn),
    .en        (!bus.stall),
    .push      (push_s),
    .push_data (pc4_s),
    .pop       (pop_s),
    .pop_cmp   (bus.rd1),
    .top       (bus.ras_top),
    .valid     (bus.ras_valid),
    .miss_cnt  (bus.ras_miss_cnt)
  );

  assign bus.pc       = pc_q;
  assign bus.epc      = epc_q;
  assign bus.npc      = npc_s;
  assign bus.misalign = misalign_s;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Scoreboard bench for pc_gen_ras: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them. A second instance with a 2-bit
// miss counter exercises saturation.
module tb_pc_gen_ras;
  import pc_gen_ras_pkg::*;

  localparam int S_PC = 0, S_NPC = 1, S_EPC = 2, S_TOP = 3, S_VLD = 4,
                 S_CNT = 5, S_MIS = 6, S_SAT = 7;

  typedef struct {
    int          tag;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pc_gen_ras_if #(.CNT_W(16)) bus ();
  pc_gen_ras_if #(.CNT_W(2))  bus2 ();

  assign bus2.stall    = bus.stall;
  assign bus2.npc_op   = bus.npc_op;
  assign bus2.imm      = bus.imm;
  assign bus2.rd1      = bus.rd1;
  assign bus2.link     = bus.link;
  assign bus2.rs_is_ra = bus.rs_is_ra;

  pc_gen_ras #(.RESET_PC(32'h0000_3000), .EXC_VEC(32'h0000_4180),
               .RAS_DEPTH(4), .CNT_W(16))
    dut (.clk(clk), .rstn(rstn), .bus(bus));

  pc_gen_ras #(.RESET_PC(32'h0000_3000), .EXC_VEC(32'h0000_4180),
               .RAS_DEPTH(4), .CNT_W(2))
    dut_sat (.clk(clk), .rstn(rstn), .bus(bus2));

  function automatic logic [31:0] dut_val(int sel);
    case (sel)
      S_PC:    return bus.pc;
      S_NPC:   return bus.npc;
      S_EPC:   return bus.epc;
      S_TOP:   return bus.ras_top;
      S_VLD:   return {31'd0, bus.ras_valid};
      S_CNT:   return {16'd0, bus.ras_miss_cnt};
      S_MIS:   return {31'd0, bus.misalign};
      S_SAT:   return {30'd0, bus2.ras_miss_cnt};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every expectation due in this cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
      e   = sbq.pop_front();
      act = dut_val(e.sel);
      n_tests++;
      if (e.tag != cyc) begin
        n_fail++;
        $display("FAIL %s: not checked in cycle %0d (now %0d)", e.name, e.tag, cyc);
      end else if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic exp_now(int sel, logic [31:0] v, string nm);
    sbq.push_back('{cyc, sel, v, nm});
  endtask

  task automatic exp_nxt(int sel, logic [31:0] v, string nm);
    sbq.push_back('{cyc + 1, sel, v, nm});
  endtask

  task automatic drive(logic [2:0] op, logic [25:0] imm, logic [31:0] rd1,
                       logic link, logic rsra, logic stall);
    bus.npc_op   = op;
    bus.imm      = imm;
    bus.rd1      = rd1;
    bus.link     = link;
    bus.rs_is_ra = rsra;
    bus.stall    = stall;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    drive(NPC_PLUS4, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b0;
    repeat (2) tick;
    exp_now(S_PC,  32'h0000_3000, "rst_pc");
    exp_now(S_EPC, 32'h0000_0000, "rst_epc");
    exp_now(S_TOP, 32'h0000_0000, "rst_top");
    exp_now(S_VLD, 32'd0, "rst_valid");
    exp_now(S_CNT, 32'd0, "rst_cnt");
    exp_now(S_MIS, 32'd0, "rst_misalign");
    rstn = 1'b1;

    for (int i = 0; i < 4; i++) begin
      exp_now(S_NPC, 32'h0000_3004 + 32'(4 * i), "plus4_npc");
      exp_nxt(S_PC,  32'h0000_3004 + 32'(4 * i), "plus4_pc");
      tick;
    end

    drive(NPC_BRANCH, 26'h000FFFE, 32'd0, 1'b0, 1'b0, 1'b1);
    exp_now(S_NPC, 32'h0000_300C, "branch_back_npc");
    exp_nxt(S_PC,  32'h0000_3010, "branch_stall_pc");
    tick;
    drive(NPC_JUMP, 26'h0000C40, 32'd0, 1'b0, 1'b0, 1'b0);
    exp_now(S_NPC, 32'h0000_3100, "jump_npc");
    exp_nxt(S_PC,  32'h0000_3100, "jump_pc");
    tick;

    drive(NPC_JUMP, 26'h0000C80, 32'd0, 1'b1, 1'b0, 1'b0);
    exp_nxt(S_PC,  32'h0000_3200, "jal_pc");
    exp_nxt(S_TOP, 32'h0000_3104, "jal_top");
    exp_nxt(S_VLD, 32'd1, "jal_valid");
    tick;
    drive(NPC_JR, 26'd0, 32'h0000_3104, 1'b0, 1'b1, 1'b0);
    exp_now(S_NPC, 32'h0000_3104, "jr_npc");
    exp_nxt(S_VLD, 32'd0, "jr_hit_valid");
    exp_nxt(S_TOP, 32'h0000_0000, "jr_hit_top");
    exp_nxt(S_CNT, 32'd0, "jr_hit_cnt");
    tick;
    drive(NPC_JUMP, 26'h0000C80, 32'd0, 1'b1, 1'b0, 1'b0);
    exp_nxt(S_TOP, 32'h0000_3108, "jal2_top");
    tick;
    drive(NPC_JR, 26'd0, 32'h0000_310C, 1'b0, 1'b1, 1'b0);
    exp_nxt(S_CNT, 32'd1, "jr_miss_cnt");
    exp_nxt(S_VLD, 32'd0, "jr_miss_valid");
    exp_nxt(S_PC,  32'h0000_310C, "jr_miss_pc");
    tick;

    for (int i = 0; i < 5; i++) begin
      drive(NPC_PLUS4, 26'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      exp_nxt(S_TOP, 32'h0000_3110 + 32'(4 * i), "push_top");
      exp_nxt(S_VLD, 32'd1, "push_valid");
      tick;
    end
    for (int i = 0; i < 4; i++) begin
      rd = 32'h0000_3120 - 32'(4 * i);
      drive(NPC_JR, 26'd0, rd, 1'b0, 1'b1, 1'b0);
      exp_nxt(S_PC,  rd, "pop_pc");
      exp_nxt(S_CNT, 32'd1, "pop_cnt");
      exp_nxt(S_VLD, (i < 3) ? 32'd1 : 32'd0, "pop_valid");
      exp_nxt(S_TOP, (i < 3) ? rd - 32'h0000_0004 : 32'h0000_0000, "pop_top");
      tick;
    end
    drive(NPC_JR, 26'd0, 32'h0000_3110, 1'b0, 1'b1, 1'b0);
    exp_nxt(S_CNT, 32'd2, "pop_empty_cnt");
    exp_nxt(S_SAT, 32'd2, "pop_empty_sat");
    exp_nxt(S_PC,  32'h0000_3110, "pop_empty_pc");
    tick;

    drive(NPC_PLUS4, 26'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    exp_nxt(S_TOP, 32'h0000_3114, "pre_jalr_top");
    tick;
    drive(NPC_JR, 26'd0, 32'h0000_3114, 1'b1, 1'b1, 1'b0);
    exp_nxt(S_TOP, 32'h0000_3118, "jalr_top");
    exp_nxt(S_VLD, 32'd1, "jalr_valid");
    exp_nxt(S_CNT, 32'd2, "jalr_cnt");
    tick;
    drive(NPC_JR, 26'd0, 32'h0000_3118, 1'b0, 1'b1, 1'b0);
    exp_nxt(S_VLD, 32'd0, "post_jalr_valid");
    exp_nxt(S_CNT, 32'd2, "post_jalr_cnt");
    tick;
    drive(NPC_JR, 26'd0, 32'h0000_3200, 1'b0, 1'b1, 1'b0);
    exp_nxt(S_SAT, 32'd3, "sat_reach");
    tick;
    exp_nxt(S_CNT, 32'd4, "cnt_wide");
    exp_nxt(S_SAT, 32'd3, "sat_hold");
    exp_nxt(S_PC,  32'h0000_3200, "sat_pc");
    tick;

    drive(NPC_EXC, 26'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    exp_now(S_NPC, 32'h0000_4180, "exc_npc");
    exp_nxt(S_PC,  32'h0000_3200, "exc_stall_pc");
    exp_nxt(S_EPC, 32'h0000_0000, "exc_stall_epc");
    tick;
    drive(NPC_EXC, 26'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    exp_nxt(S_PC,  32'h0000_4180, "exc_pc");
    exp_nxt(S_EPC, 32'h0000_3200, "exc_epc");
    exp_nxt(S_VLD, 32'd0, "exc_no_push");
    tick;
    drive(NPC_ERET, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    exp_now(S_NPC, 32'h0000_3200, "eret_npc");
    exp_nxt(S_PC,  32'h0000_3200, "eret_pc");
    tick;
    drive(NPC_PLUS4, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    exp_nxt(S_PC, 32'h0000_3204, "post_eret_pc");
    tick;

    drive(NPC_JR, 26'd0, 32'h0000_3002, 1'b0, 1'b0, 1'b0);
`ifdef PC_ALIGN_CHK_EN
    exp_now(S_NPC, 32'h0000_4180, "misalign_npc");
    exp_now(S_MIS, 32'd1, "misalign_flag");
    exp_nxt(S_PC,  32'h0000_4180, "misalign_pc");
    exp_nxt(S_EPC, 32'h0000_3204, "misalign_epc");
`else
    exp_now(S_NPC, 32'h0000_3002, "misalign_npc");
    exp_now(S_MIS, 32'd0, "misalign_flag");
    exp_nxt(S_PC,  32'h0000_3002, "misalign_pc");
    exp_nxt(S_EPC, 32'h0000_3200, "misalign_epc");
`endif
    tick;
    drive(NPC_PLUS4, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    exp_now(S_MIS, 32'd0, "misalign_clear");
    tick;

    rstn = 1'b0;
    exp_now(S_PC,  32'h0000_3000, "midrst_pc");
    exp_now(S_EPC, 32'h0000_0000, "midrst_epc");
    exp_now(S_CNT, 32'd0, "midrst_cnt");
    exp_now(S_SAT, 32'd0, "midrst_sat");
    tick;
    rstn = 1'b1;

    for (int i = 0; i < 10 && sbq.size() > 0; i++) tick;
    if (sbq.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
